// File: rtl/micro_seq.sv
// micro_seq: microprogram sequencer for the CPU control unit.
// It holds the control address register (CAR) and a return-address stack.
// Each cycle it picks the next control address from the branch field,
// the address field, the opcode map address and the selected condition.
// All outputs come straight from registers.
module micro_seq #(
  parameter int AW         = 7,
  parameter int SD         = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_hold,
  input  logic                     i_cond,
  input  logic [1:0]               i_br,
  input  logic [AW-1:0]            i_ad,
  input  logic [AW-1:0]            i_map,
  input  logic                     i_halt,
  output logic [AW-1:0]            o_car,
  output logic                     o_busy,
  output logic [$clog2(SD+1)-1:0]  o_sp,
  output logic                     o_err
);

  localparam int SPW = $clog2(SD+1);
  // The array is sized to the full index range so the SPW-bit pointer
  // addresses it exactly; only the first SD entries are ever written.
  localparam int STK_N = 1 << SPW;
  localparam logic [AW-1:0]  C_RST_ADDR = AW'(RESET_ADDR);
  localparam logic [SPW-1:0] C_SP_FULL  = SPW'(SD);
  localparam logic [SPW-1:0] C_SP_ZERO  = {SPW{1'b0}};

  localparam logic [1:0] BR_JMP  = 2'b00;
  localparam logic [1:0] BR_CALL = 2'b01;
  localparam logic [1:0] BR_RET  = 2'b10;
  localparam logic [1:0] BR_MAP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_car;
  logic [SPW-1:0]  r_sp;
  logic            r_err;
  logic            r_busy;
  logic [AW-1:0]   r_stack [0:STK_N-1];

  state_t          w_state_nxt;
  logic [AW-1:0]   w_car_nxt;
  logic [SPW-1:0]  w_sp_nxt;
  logic            w_err_nxt;
  logic            w_push;
  logic [AW-1:0]   w_car_inc;
  logic [SPW-1:0]  w_sp_inc;
  logic [SPW-1:0]  w_sp_dec;
  logic [AW-1:0]   w_top;

  // Increment wraps naturally at the address width.
  assign w_car_inc = r_car + AW'(1);
  assign w_sp_inc  = r_sp + SPW'(1);
  assign w_sp_dec  = r_sp - SPW'(1);
  assign w_top     = r_stack[w_sp_dec];

  // Next-state, next-address and stack-pointer selection.
  always_comb begin
    w_state_nxt = r_state;
    w_car_nxt   = r_car;
    w_sp_nxt    = r_sp;
    w_err_nxt   = r_err;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_car_nxt = C_RST_ADDR;
        w_sp_nxt  = C_SP_ZERO;
        w_err_nxt = 1'b0;
        if (i_start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_hold) begin
          // Stall: everything keeps its value.
          w_state_nxt = S_RUN;
        end else if (i_halt) begin
          w_state_nxt = S_IDLE;
          w_car_nxt   = C_RST_ADDR;
          w_sp_nxt    = C_SP_ZERO;
        end else begin
          case (i_br)
            BR_JMP: begin
              if (i_cond) begin
                w_car_nxt = i_ad;
              end else begin
                w_car_nxt = w_car_inc;
              end
            end
            BR_CALL: begin
              if (!i_cond) begin
                w_car_nxt = w_car_inc;
              end else if (r_sp == C_SP_FULL) begin
                // Overflow: freeze CAR and stack at the offending CALL.
                w_state_nxt = S_FAULT;
                w_err_nxt   = 1'b1;
              end else begin
                w_push    = 1'b1;
                w_sp_nxt  = w_sp_inc;
                w_car_nxt = i_ad;
              end
            end
            BR_RET: begin
              if (r_sp == C_SP_ZERO) begin
                w_state_nxt = S_FAULT;
                w_err_nxt   = 1'b1;
              end else begin
                w_sp_nxt  = w_sp_dec;
                w_car_nxt = w_top;
              end
            end
            BR_MAP: begin
              w_car_nxt = i_map;
            end
            default: begin
              w_car_nxt = r_car;
            end
          endcase
        end
      end
      S_FAULT: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_car_nxt   = C_RST_ADDR;
          w_sp_nxt    = C_SP_ZERO;
          w_err_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_FAULT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_car_nxt   = C_RST_ADDR;
        w_sp_nxt    = C_SP_ZERO;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  // State, CAR, stack pointer, error and busy registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_car   <= C_RST_ADDR;
      r_sp    <= C_SP_ZERO;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_car   <= w_car_nxt;
      r_sp    <= w_sp_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
    end
  end

  // Return-address stack storage; contents above sp are don't-care.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_stack[r_sp] <= w_car_inc;
    end
  end

  assign o_car  = r_car;
  assign o_sp   = r_sp;
  assign o_err  = r_err;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_micro_seq.sv
// Scoreboard bench for micro_seq: a behavioural model predicts the
// outputs after each clock; a separate monitor compares them.
module tb_micro_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_hold = 1'b0;
  logic       i_cond = 1'b0;
  logic [1:0] i_br = 2'b00;
  logic [6:0] i_ad = 7'd0;
  logic [6:0] i_map = 7'd0;
  logic       i_halt = 1'b0;
  logic [6:0] o_car;
  logic       o_busy;
  logic [2:0] o_sp;
  logic       o_err;

  micro_seq #(.AW(7), .SD(4), .RESET_ADDR(0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_hold(i_hold),
    .i_cond(i_cond), .i_br(i_br), .i_ad(i_ad), .i_map(i_map), .i_halt(i_halt),
    .o_car(o_car), .o_busy(o_busy), .o_sp(o_sp), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int car;
    int sp;
    int busy;
    int err;
    int step;
  } exp_t;

  exp_t q[$];
  event ev_chk;
  int n_total = 0;
  int n_pass  = 0;
  int step_no = 0;

  // Reference model: mode 0 idle, 1 run, 2 fault; stack as a queue.
  int m_mode = 0;
  int m_car  = 0;
  int m_err  = 0;
  int m_stk[$];

  task automatic model_reset();
    m_mode = 0; m_car = 0; m_err = 0; m_stk.delete();
  endtask

  task automatic model_step(input bit st, input bit h, input bit c,
                            input int br, input int ad, input int mp, input bit hl);
    if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (m_mode == 2) begin
      if (st) begin
        m_mode = 1; m_car = 0; m_err = 0; m_stk.delete();
      end
    end else if (!h) begin
      if (hl) begin
        m_mode = 0; m_car = 0; m_stk.delete();
      end else if (br == 0) begin
        m_car = c ? ad : (m_car + 1) % 128;
      end else if (br == 1) begin
        if (c) begin
          if (m_stk.size() == 4) begin
            m_mode = 2; m_err = 1;
          end else begin
            m_stk.push_back((m_car + 1) % 128);
            m_car = ad;
          end
        end else begin
          m_car = (m_car + 1) % 128;
        end
      end else if (br == 2) begin
        if (m_stk.size() == 0) begin
          m_mode = 2; m_err = 1;
        end else begin
          m_car = m_stk.pop_back();
        end
      end else begin
        m_car = mp;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.car = m_car; e.sp = m_stk.size(); e.busy = (m_mode == 1) ? 1 : 0;
    e.err = m_err; e.step = step_no;
    q.push_back(e);
    step_no++;
  endtask

  // One microinstruction cycle: drive at negedge, predict the post-edge state.
  task automatic cyc(input bit st, input bit h, input bit c, input int br,
                     input int ad, input int mp, input bit hl);
    @(negedge i_clk);
    i_start = st; i_hold = h; i_cond = c; i_br = 2'(br);
    i_ad = 7'(ad); i_map = 7'(mp); i_halt = hl;
    model_step(st, h, c, br, ad, mp, hl);
    push_exp();
  endtask

  // Asynchronous reset mid-cycle, checked before the next clock edge.
  task automatic do_reset();
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    model_reset();
    push_exp();
    #1;
    -> ev_chk;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] want, input int stp);
    n_total++;
    if (act === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s step %0d: got %0h expected %0h", nm, stp, act, want);
    end
  endfunction

  // Sample point just after each rising edge.
  always @(posedge i_clk) begin
    #1;
    -> ev_chk;
  end

  // Monitor: pop every pending expectation and compare with the DUT.
  initial begin
    exp_t e;
    forever begin
      @(ev_chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("car",  {25'd0, o_car},  32'(e.car),  e.step);
        chk("sp",   {29'd0, o_sp},   32'(e.sp),   e.step);
        chk("busy", {31'd0, o_busy}, 32'(e.busy), e.step);
        chk("err",  {31'd0, o_err},  32'(e.err),  e.step);
      end
    end
  end

  initial begin
    do_reset();
    // Build CAR=0x23, sp=2 then reset mid-RUN.
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h20, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h22, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    // JMP and wrap.
    cyc(1'b0, 1'b0, 1'b1, 0, 7'h10, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 7'h55, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 0, 7'h40, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 0, 7'h7F, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 7'h12, 0, 1'b0);
    // CALL/RET nesting.
    cyc(1'b0, 1'b0, 1'b1, 0, 7'h05, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h30, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h50, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2, 7'h11, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 2, 7'h11, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1, 7'h66, 0, 1'b0);
    // Overflow on the fifth taken CALL, then a frozen FAULT cycle.
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h10, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h20, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h30, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h40, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h50, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 0, 7'h11, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    // Underflow.
    cyc(1'b0, 1'b0, 1'b1, 2, 0, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    // MAP, hold over halt, then halt.
    cyc(1'b0, 1'b0, 1'b0, 3, 7'h01, 7'h2C, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1, 7'h01, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 2, 7'h01, 0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 3, 7'h01, 7'h33, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1, 7'h01, 0, 1'b1);
    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
            $urandom_range(0, 24) == 0);
      end
    end
    @(negedge i_clk);
    i_start = 1'b0; i_hold = 1'b0; i_halt = 1'b0;
    repeat (3) @(negedge i_clk);
    n_total++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
